// File: rtl/stft_frame_reader_if.sv
// Sample stream from the STFT frame reader to the FFT input.
// master drives data/valid/sof/eof; slave returns ready.
interface stft_frame_reader_if #(
   parameter int WL = 16
);
   logic [WL-1:0] data;
   logic          valid;
   logic          ready;
   logic          sof;
   logic          eof;

   modport master (output data, output valid, output sof, output eof, input ready);
   modport slave  (input data, input valid, input sof, input eof, output ready);
endinterface

// File: rtl/stft_frame_reader.sv
// STFT frame reader: pulls overlapping N_FFT-sample frames out of a circular
// sample RAM, advancing the frame base by HOP, and streams them downstream
// through a 2-entry skid FIFO with SOF/EOF tags.
// Optional build macro STFT_BITREV_EN: frames are emitted in bit-reversed
// index order for an in-place radix-2 FFT; otherwise natural order.
//
// state | meaning
// IDLE  | stopped, waiting for en
// WAIT  | enabled, waiting until a full frame is in the buffer
// READ  | issuing the N_FFT reads of the current frame
// DRAIN | en dropped, emptying the read pipe and FIFO before IDLE
module stft_frame_reader #(
   parameter int WL    = 16,
   parameter int AW    = 8,
   parameter int LOG2N = 6,
   parameter int HOP   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic [AW-1:0]        wr_ptr,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [WL-1:0]        rd_data,
   output logic                 busy,
   stft_frame_reader_if.master  strm
);

   localparam int N_FFT = 1 << LOG2N;

   typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     base;
   logic [LOG2N-1:0]  k;
   logic [LOG2N-1:0]  idx;
   logic [AW-1:0]     avail;
   logic              last_k;
   logic              room;
   logic              pop;

   logic              inflight;
   logic              infl_sof;
   logic              infl_eof;

   logic [WL+1:0]     fifo [2];
   logic [1:0]        count;
   logic              rd_idx;
   logic              wr_idx;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

`ifdef STFT_BITREV_EN
   assign idx = bitrev(k);
`else
   assign idx = k;
`endif

   assign avail   = wr_ptr - base;
   assign rd_addr = base + AW'(idx);
   assign last_k  = &k;
   assign pop     = strm.valid & strm.ready;
   // Occupancy after this cycle's pop plus the read in flight; counting the
   // pop lets the pipe sustain one sample per cycle without ever overfilling.
   assign room    = (count - {1'b0, pop} + {1'b0, inflight}) < 2'd2;

   assign strm.valid = (count != 2'd0);
   assign strm.data  = fifo[rd_idx][WL-1:0];
   assign strm.sof   = strm.valid & fifo[rd_idx][WL+1];
   assign strm.eof   = strm.valid & fifo[rd_idx][WL];
   assign busy       = (state != IDLE) | (count != 2'd0) | inflight;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and read strobe; clr overrides everything.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         IDLE:  if (en) state_nxt = WAIT;
         WAIT: begin
            if (!en)                          state_nxt = DRAIN;
            else if (avail >= AW'(N_FFT))     state_nxt = READ;
         end
         READ: begin
            rd_en = room;
            if (room && last_k) state_nxt = en ? WAIT : DRAIN;
         end
         DRAIN: if (count == 2'd0 && !inflight) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clr) begin
         state_nxt = IDLE;
         rd_en     = 1'b0;
      end
   end

   // Frame base and sample index; base steps by HOP after the last read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base <= '0;
         k    <= '0;
      end else if (clr) begin
         base <= '0;
         k    <= '0;
      end else if (rd_en) begin
         if (last_k) begin
            k    <= '0;
            base <= base + AW'(HOP);
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   // One-cycle read pipe carrying the SOF/EOF tags alongside the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 1'b0;
         infl_sof <= 1'b0;
         infl_eof <= 1'b0;
      end else begin
         inflight <= rd_en;
         infl_sof <= (k == '0);
         infl_eof <= last_k;
      end
   end

   // Skid FIFO: captures returning read data, drained by the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) fifo[i] <= '0;
         count  <= '0;
         rd_idx <= 1'b0;
         wr_idx <= 1'b0;
      end else if (clr) begin
         count  <= '0;
         rd_idx <= 1'b0;
         wr_idx <= 1'b0;
      end else begin
         if (inflight) begin
            fifo[wr_idx] <= {infl_sof, infl_eof, rd_data};
            wr_idx       <= ~wr_idx;
         end
         if (pop) rd_idx <= ~rd_idx;
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule
